// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: one access at a time through IDLE -> ACCESS -> RESP,
// round-robin or port-0-priority arbitration, with alignment/range checking per access.
module dmem_arbiter #(
   parameter int DMEM_SIZE  = 64,
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [29:0] DEPTH = 30'(DMEM_SIZE);

   state_t      state_q, state_d;
   logic        win_q, win_d;
   logic        last_q, last_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic arb_win;
   logic legal;

   // On a tie the round-robin pointer favours the port that was not granted last.
   assign arb_win = (p0_req && p1_req) ? ((FIXED_PRIO != 0) ? 1'b0 : ~last_q) : p1_req;
   assign legal   = (addr_q[1:0] == 2'b00) && (addr_q[31:2] < DEPTH);
   assign busy    = (state_q != IDLE);

   always_comb begin
      state_d     = state_q;
      win_d       = win_q;
      last_d      = last_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_addr    = mem_addr_q;
      mem_wdata   = mem_wdata_q;
      p0_gnt      = 1'b0;
      p0_rdata    = 32'h0;
      p0_err      = 1'b0;
      p1_gnt      = 1'b0;
      p1_rdata    = 32'h0;
      p1_err      = 1'b0;
      case (state_q)
         IDLE: begin
            if (p0_req || p1_req) begin
               win_d   = arb_win;
               we_d    = arb_win ? p1_we    : p0_we;
               addr_d  = arb_win ? p1_addr  : p0_addr;
               wdata_d = arb_win ? p1_wdata : p0_wdata;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            mem_addr    = addr_q;
            mem_wdata   = wdata_q;
            mem_addr_d  = addr_q;
            mem_wdata_d = wdata_q;
            if (legal) begin
               mem_write = we_q;
               mem_read  = ~we_q;
               rdata_d   = mem_rdata;
               err_d     = 1'b0;
            end else begin
               rdata_d = 32'h0;
               err_d   = 1'b1;
            end
            last_d  = win_q;
            state_d = RESP;
         end
         RESP: begin
            if (win_q) begin
               p1_gnt   = 1'b1;
               p1_rdata = rdata_q;
               p1_err   = err_q;
            end else begin
               p0_gnt   = 1'b1;
               p0_rdata = rdata_q;
               p0_err   = err_q;
            end
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pointer resets to port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         win_q       <= 1'b0;
         last_q      <= 1'b1;
         we_q        <= 1'b0;
         addr_q      <= 32'h0;
         wdata_q     <= 32'h0;
         rdata_q     <= 32'h0;
         err_q       <= 1'b0;
         mem_addr_q  <= 32'h0;
         mem_wdata_q <= 32'h0;
      end else begin
         state_q     <= state_d;
         win_q       <= win_d;
         last_q      <= last_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, tie/reset sequences and random traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_dmem_arbiter;
   localparam int DS = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  req, we;
   logic [31:0] addr [2];
   logic [31:0] wdata [2];
   logic        g0, g1, e0, e1, mem_read, mem_write, busy;
   logic [31:0] rd0, rd1, mem_addr, mem_wdata, mem_rdata;
   logic [31:0] tbmem [DS];

   assign mem_rdata = tbmem[mem_addr[7:2]];
   always @(posedge clk) if (mem_write) tbmem[mem_addr[7:2]] <= mem_wdata;

   dmem_arbiter #(.DMEM_SIZE(DS), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst),
      .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
      .p0_gnt(g0), .p0_rdata(rd0), .p0_err(e0),
      .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
      .p1_gnt(g1), .p1_rdata(rd1), .p1_err(e1),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

   // Fixed-priority instance with both ports requesting for the whole run.
   logic        fg0, fg1, fe0, fe1, fmr, fmw, fbusy;
   logic [31:0] frd0, frd1, fma, fmwd;
   int          fp0_cnt = 0, fp1_cnt = 0;

   dmem_arbiter #(.DMEM_SIZE(DS), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_req(1'b1), .p0_we(1'b0), .p0_addr(32'h0), .p0_wdata(32'h0),
      .p0_gnt(fg0), .p0_rdata(frd0), .p0_err(fe0),
      .p1_req(1'b1), .p1_we(1'b0), .p1_addr(32'h4), .p1_wdata(32'h0),
      .p1_gnt(fg1), .p1_rdata(frd1), .p1_err(fe1),
      .mem_read(fmr), .mem_write(fmw), .mem_addr(fma),
      .mem_wdata(fmwd), .mem_rdata(32'h0), .busy(fbusy));

   always @(negedge clk) begin
      if (fg0) fp0_cnt <= fp0_cnt + 1;
      if (fg1) fp1_cnt <= fp1_cnt + 1;
   end

   int          total = 0, bad = 0;
   logic [1:0]  pend;
   logic        model_last;
   logic [31:0] model_mem [DS];

   typedef struct {
      int          port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   function automatic logic legal(input logic [31:0] a);
      return (a % 4 == 0) && (a / 4 < DS);
   endfunction

   function automatic void model_apply(input logic w_e, input logic [31:0] a,
                                       input logic [31:0] d, output logic [31:0] r,
                                       output logic e);
      if (!legal(a)) begin
         r = 32'h0;
         e = 1'b1;
      end else begin
         r = model_mem[a / 4];
         e = 1'b0;
         if (w_e) model_mem[a / 4] = d;
      end
   endfunction

   function automatic int pick();
      if (pend == 2'b11) return model_last ? 0 : 1;
      return pend[1] ? 1 : 0;
   endfunction

   task automatic new_op(input int p);
      int k;
      k = $urandom_range(0, 7);
      pend[p]  = 1'b1;
      we[p]    = 1'($urandom_range(0, 1));
      wdata[p] = $urandom;
      case (k)
         0:       addr[p] = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
         1:       addr[p] = 32'($urandom_range(64, 2000)) * 4;
         2:       addr[p] = $urandom;
         default: addr[p] = 32'($urandom_range(0, 63)) * 4;
      endcase
   endtask

   // Called at a negedge with the DUT idle; drives pend, expects port w to win.
   task automatic run_round(input bit keep_w, input int w, input logic [31:0] exp_rd,
                            input logic exp_err);
      logic lg;
      lg  = legal(addr[w]);
      req = pend;
      @(posedge clk); #1;
      chk("acc_busy", busy, 1);
      chk("acc_read", mem_read, lg && !we[w]);
      chk("acc_write", mem_write, lg && we[w]);
      chk("acc_gnt", {g1, g0}, 0);
      if (lg) chk("acc_addr", mem_addr, addr[w]);
      if (lg && we[w]) chk("acc_wdata", mem_wdata, wdata[w]);
      @(posedge clk); #1;
      chk("gnt", {g1, g0}, (w == 1) ? 2'b10 : 2'b01);
      chk("rdata", (w == 1) ? rd1 : rd0, exp_rd);
      chk("err", (w == 1) ? e1 : e0, exp_err);
      chk("other_rdata", (w == 1) ? rd0 : rd1, 0);
      chk("other_err", (w == 1) ? e0 : e1, 0);
      chk("resp_strobe", {mem_read, mem_write}, 0);
      if (!keep_w) begin
         pend[w] = 1'b0;
         req[w]  = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("gnt_pulse", {g1, g0}, 0);
   endtask

   initial begin
      logic [31:0] r;
      logic        e;
      int          w;
      int          gp[$];
      int          gc[$];

      for (int i = 0; i < DS; i++) begin
         tbmem[i]     = 32'hC0DE0000 + 32'(i);
         model_mem[i] = 32'hC0DE0000 + 32'(i);
      end
      tbmem[2]     = 32'hDEADBEEF;
      model_mem[2] = 32'hDEADBEEF;

      tbl[0]  = '{0, 1'b0, 32'h08,       32'h0,        32'hDEADBEEF, 1'b0};
      tbl[1]  = '{1, 1'b1, 32'h04,       32'h12345678, 32'hC0DE0001, 1'b0};
      tbl[2]  = '{0, 1'b0, 32'h04,       32'h0,        32'h12345678, 1'b0};
      tbl[3]  = '{1, 1'b1, 32'h100,      32'h55555555, 32'h0,        1'b1};
      tbl[4]  = '{1, 1'b1, 32'h06,       32'h66666666, 32'h0,        1'b1};
      tbl[5]  = '{0, 1'b0, 32'hFC,       32'h0,        32'hC0DE003F, 1'b0};
      tbl[6]  = '{1, 1'b0, 32'h100,      32'h0,        32'h0,        1'b1};
      tbl[7]  = '{0, 1'b0, 32'h03,       32'h0,        32'h0,        1'b1};
      tbl[8]  = '{1, 1'b0, 32'h10,       32'h0,        32'hC0DE0004, 1'b0};
      tbl[9]  = '{0, 1'b1, 32'hFC,       32'hAAAA5555, 32'hC0DE003F, 1'b0};
      tbl[10] = '{1, 1'b0, 32'hFC,       32'h0,        32'hAAAA5555, 1'b0};
      tbl[11] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b1};

      // Reset state, with both ports already requesting for the tie sequence.
      rst = 1'b0;
      req = 2'b11;
      we  = 2'b00;
      addr[0] = 32'h0;  addr[1] = 32'h4;
      wdata[0] = 32'h0; wdata[1] = 32'h0;
      pend = 2'b00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_gnt", {g1, g0}, 0);
      chk("rst_err", {e1, e0}, 0);
      chk("rst_strobe", {mem_read, mem_write}, 0);
      chk("rst_rdata0", rd0, 0);
      chk("rst_rdata1", rd1, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);

      // Continuous tie from reset: p0, p1, p0, p1 three cycles apart.
      @(negedge clk) rst = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (g0) begin gp.push_back(0); gc.push_back(c); end
         if (g1) begin gp.push_back(1); gc.push_back(c); end
      end
      req = 2'b00;
      chk("rr_count", gp.size(), 4);
      for (int i = 0; i < 4 && i < gp.size(); i++) begin
         chk("rr_port", gp[i], i % 2);
         chk("rr_cycle", gc[i], 2 + 3 * i);
      end
      model_last = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 12; i++) begin
         pend = 2'b00;
         pend[tbl[i].port]  = 1'b1;
         we[tbl[i].port]    = tbl[i].we;
         addr[tbl[i].port]  = tbl[i].addr;
         wdata[tbl[i].port] = tbl[i].wdata;
         model_apply(tbl[i].we, tbl[i].addr, tbl[i].wdata, r, e);
         run_round(1'b0, tbl[i].port, tbl[i].exp_rd, tbl[i].exp_err);
         model_last = 1'(tbl[i].port);
      end

      pend = 2'b00;
      for (int n = 0; n < 60; n++) begin
         for (int p = 0; p < 2; p++)
            if (!pend[p] && $urandom_range(0, 1) == 1) new_op(p);
         if (pend == 2'b00) new_op(int'($urandom_range(0, 1)));
         w = pick();
         model_apply(we[w], addr[w], wdata[w], r, e);
         run_round($urandom_range(0, 3) == 0, w, r, e);
         model_last = 1'(w);
      end

      // Point the pointer at p1, then abort a p1 access with reset.
      pend = 2'b01;
      req  = 2'b00;
      we[0] = 1'b0; addr[0] = 32'h0;
      model_apply(1'b0, 32'h0, 32'h0, r, e);
      run_round(1'b0, 0, r, e);
      model_last = 1'b0;
      pend = 2'b10;
      we[1] = 1'b0; addr[1] = 32'h10;
      req = pend;
      @(posedge clk); #1;
      chk("abort_busy_pre", busy, 1);
      rst = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_gnt", {g1, g0}, 0);
      chk("abort_strobe", {mem_read, mem_write}, 0);
      we[0] = 1'b0; addr[0] = 32'h20;
      req = 2'b11;
      @(posedge clk); #1;
      chk("abort_gnt_hold", {g1, g0}, 0);
      @(negedge clk) rst = 1'b1;
      pend = 2'b11;
      model_last = 1'b1;
      model_apply(1'b0, addr[0], 32'h0, r, e);
      run_round(1'b0, 0, r, e);
      model_last = 1'b0;
      model_apply(1'b0, addr[1], 32'h0, r, e);
      run_round(1'b0, 1, r, e);

      chk("fp_p1_never", fp1_cnt, 0);
      chk("fp_p0_wins", fp0_cnt > 20, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DMEM_SIZE, default 64: data memory depth in 32-bit words.
REQ-002 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 gives port 0 fixed priority.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have ports p0_req / p1_req  input  1  access request, held high until the matching gnt.
REQ-006 The block SHALL have ports p0_we / p1_we  input  1  1 = write, 0 = read; held stable with req.
REQ-007 The block SHALL have ports p0_addr / p1_addr  input  32  byte address; held stable with req.
REQ-008 The block SHALL have ports p0_wdata / p1_wdata  input  32  write data; held stable with req.
REQ-009 The block SHALL have ports p0_gnt / p1_gnt  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have ports p0_rdata / p1_rdata  output  32  read data, valid while the matching gnt is high.
REQ-011 The block SHALL have ports p0_err / p1_err  output  1  error flag, valid while the matching gnt is high.
REQ-012 The block SHALL have port mem_read  output  1  memory read strobe.
REQ-013 The block SHALL have port mem_write  output  1  memory write strobe.
REQ-014 The block SHALL have port mem_addr  output  32  memory byte address.
REQ-015 The block SHALL have port mem_wdata  output  32  memory write data.
REQ-016 The block SHALL have port mem_rdata  input  32  memory read data, combinational from mem_addr.
REQ-017 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS and RESP; the sequence is IDLE -> ACCESS -> RESP -> IDLE.
REQ-019 In IDLE with any req high, the FSM SHALL register the winner index, we, addr and wdata, then go to ACCESS; with no req it SHALL stay in IDLE.
REQ-020 Arbitration SHALL follow these rules:
- only one req high: that port wins;
- both high and FIXED_PRIO=1: port 0 wins;
- both high and FIXED_PRIO=0: the port not granted last wins;
- the last-granted pointer updates on each transition into RESP.
REQ-021 An access SHALL be illegal when addr[1:0] != 0 or addr[31:2] >= DMEM_SIZE.
REQ-022 In ACCESS for a legal access, the block SHALL drive mem_addr and mem_wdata from the registered values, assert exactly one of mem_write (we=1) or mem_read (we=0), and capture mem_rdata into the response register at the cycle end.
REQ-023 In ACCESS for an illegal access, mem_read and mem_write SHALL stay 0, the response data SHALL be 0, and the error bit SHALL be set.
REQ-024 In RESP, the winner's gnt SHALL be high for exactly one cycle, with its rdata and err driven from the response registers.
REQ-025 The non-winner's gnt and err SHALL be 0, and its rdata SHALL be 0.
REQ-026 Outside ACCESS, mem_read and mem_write SHALL be 0; mem_addr and mem_wdata SHALL hold their last values.
REQ-027 Latency SHALL be fixed: a req sampled in IDLE at edge N produces gnt in cycle N+2.
REQ-028 Back-to-back throughput SHALL be one access per 3 cycles.
REQ-029 A request latched in IDLE SHALL be committed: deasserting req afterwards does not cancel the access or the gnt.
REQ-030 A requester that keeps req high after its gnt SHALL be treated as a new request at the next IDLE.
REQ-031 Requests arriving while busy=1 SHALL wait; they are not lost, because req is held.
REQ-032 rdata for a write SHALL be the memory contents at mem_addr sampled in ACCESS, which is the old value before the write.

Reset
REQ-033 While rst=0, the FSM SHALL be IDLE and all gnt, err, mem_read, mem_write and busy SHALL be 0.
REQ-034 While rst=0, all rdata, mem_addr, mem_wdata and registered request fields SHALL be 0.
REQ-035 While rst=0, the last-granted pointer SHALL be 1, so port 0 wins the first tie.
REQ-036 Reset asserted during ACCESS or RESP SHALL abort the access with no gnt issued; a memory write already strobed may complete.

Verification
REQ-037 Single read: p0_req=1, p0_we=0, p0_addr=0x08 with mem word 2 = 0xDEADBEEF -> mem_read=1 with mem_addr=0x08 in cycle N+1; p0_gnt=1, p0_rdata=0xDEADBEEF, p0_err=0 in cycle N+2.
REQ-038 Round-robin tie: both req high continuously from reset -> gnt order p0, p1, p0, p1, gnts 3 cycles apart.
REQ-039 Fixed priority: FIXED_PRIO=1, both req high -> p0 wins every arbitration and p1_gnt never asserts.
REQ-040 Illegal access: p1 write to addr 0x100 with DMEM_SIZE=64, then separately to addr 0x06 -> no mem_write; p1_gnt=1, p1_err=1, p1_rdata=0 for each.
REQ-041 Write then read: p1 writes 0x12345678 to 0x04, then p0 reads 0x04 -> p0_rdata=0x12345678.
REQ-042 Reset mid-access: rst=0 asserted in ACCESS -> no gnt; busy=0 immediately; after release, a tie grants p0 first.
